// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : y86_pkg
//  Description : Shared definitions for the Y86 SEQ processor control path.
//                Holds the status codes, the instruction codes, the stage
//                indices and the sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

    // Processor status codes
    localparam logic [2:0] c_stat_aok = 3'd1;
    localparam logic [2:0] c_stat_hlt = 3'd2;
    localparam logic [2:0] c_stat_adr = 3'd3;
    localparam logic [2:0] c_stat_ins = 3'd4;
    localparam logic [2:0] c_stat_tmo = 3'd5;

    // Instruction codes
    localparam logic [3:0] c_icode_halt  = 4'd0;
    localparam logic [3:0] c_icode_nop   = 4'd1;
    localparam logic [3:0] c_icode_cmov  = 4'd2;
    localparam logic [3:0] c_icode_irmov = 4'd3;
    localparam logic [3:0] c_icode_rmmov = 4'd4;
    localparam logic [3:0] c_icode_mrmov = 4'd5;
    localparam logic [3:0] c_icode_opq   = 4'd6;
    localparam logic [3:0] c_icode_jxx   = 4'd7;
    localparam logic [3:0] c_icode_call  = 4'd8;
    localparam logic [3:0] c_icode_ret   = 4'd9;
    localparam logic [3:0] c_icode_push  = 4'd10;
    localparam logic [3:0] c_icode_pop   = 4'd11;

    // Stage indices: bit positions in stage_go / stage_done
    localparam int c_stg_fet    = 0;
    localparam int c_stg_dec    = 1;
    localparam int c_stg_exe    = 2;
    localparam int c_stg_mem    = 3;
    localparam int c_stg_wb     = 4;
    localparam int c_stg_pcu    = 5;
    localparam int c_num_stages = 6;

    // Stage states share their encoding with the stage index, so a state
    // value can be used directly as a bit position in stage_go/stage_done.
    typedef enum logic [2:0] {
        ST_FET    = 3'(c_stg_fet),
        ST_DEC    = 3'(c_stg_dec),
        ST_EXE    = 3'(c_stg_exe),
        ST_MEM    = 3'(c_stg_mem),
        ST_WB     = 3'(c_stg_wb),
        ST_PCU    = 3'(c_stg_pcu),
        ST_IDLE   = 3'd6,
        ST_HALTED = 3'd7
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/stage_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : stage_watchdog
//  Description : Per-stage timeout counter. Cleared on every stage entry,
//                counts cycles spent waiting for done, and flags expiry in
//                the cycle that would bring the count to TIMEOUT.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_clear         - restart count from zero (state entry)
//                i_count_en      - a cycle passed without done
//                o_expire        - this cycle is the TIMEOUT-th miss
//  Revision    : 1.0 - initial release
// ============================================================================
module stage_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expire
);

    localparam int              c_cnt_w = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_count;

    // r_count holds the misses already seen in this stage, so the miss
    // happening now is the TIMEOUT-th one when r_count == TIMEOUT-1.
    assign o_expire = i_count_en && (r_count == c_limit);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_count_en && !o_expire) begin
            r_count <= r_count + c_one;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : seq_stage_sequencer
//  Description : Central control FSM of the Y86 SEQ processor. Walks each
//                instruction through FET, DEC, EXE, MEM, WB and PCU with a
//                go/done handshake per stage, owns the status code, the
//                CC and PC write enables and the cycle/instruction counters.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                run, pause      - start from IDLE / stop after PC update
//                stage_done[5:0] - per-stage completion {PCU..FET}
//                icode, instr_valid, imem_error - fetch results (FET done)
//                dmem_error      - data memory fault (MEM done)
//                stage_go[5:0]   - one-cycle start pulse per stage
//                cc_write_en     - latch condition codes (OPq only)
//                pc_write_en     - commit next PC
//                stat            - processor status code
//                busy            - FSM is in a stage state
//                cycle_count, instr_count - wrapping counters
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_stage_sequencer
    import y86_pkg::*;
#(
    parameter int CNT_W         = 32,
    parameter int STAGE_TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    pause,
    input  logic [c_num_stages-1:0] stage_done,
    input  logic [3:0]              icode,
    input  logic                    instr_valid,
    input  logic                    imem_error,
    input  logic                    dmem_error,
    output logic [c_num_stages-1:0] stage_go,
    output logic                    cc_write_en,
    output logic                    pc_write_en,
    output logic [2:0]              stat,
    output logic                    busy,
    output logic [CNT_W-1:0]        cycle_count,
    output logic [CNT_W-1:0]        instr_count
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    seq_state_e r_state;
    seq_state_e w_state_nxt;
    logic       r_first;        // first cycle after entering r_state
    logic [3:0] r_icode;
    logic [2:0] r_stat;
    logic [2:0] w_stat_nxt;
    logic [CNT_W-1:0] r_cycle_count;
    logic [CNT_W-1:0] r_instr_count;

    logic                    w_in_stage;
    logic [c_num_stages-1:0] w_stage_sel;
    logic                    w_done;
    logic                    w_expire;
    logic                    w_count_en;
    logic                    w_state_change;
    logic                    w_cc_we;
    logic                    w_pc_we;

    assign w_in_stage  = (r_state != ST_IDLE) && (r_state != ST_HALTED);
    assign w_stage_sel = w_in_stage ? (c_num_stages'(1) << r_state) : '0;
    // Only the done bit of the current stage matters.
    assign w_done      = |(stage_done & w_stage_sel);
    assign w_count_en  = w_in_stage && !w_done;
    assign w_state_change = (w_state_nxt != r_state);

    stage_watchdog #(
        .TIMEOUT    (STAGE_TIMEOUT)
    ) u_watchdog (
        .clk        (clk),
        .rst        (reset),
        .i_clear    (w_state_change),
        .i_count_en (w_count_en),
        .o_expire   (w_expire)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_first       <= 1'b0;
            r_icode       <= c_icode_nop;
            r_stat        <= c_stat_aok;
            r_cycle_count <= '0;
            r_instr_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_first <= w_state_change;
            r_stat  <= w_stat_nxt;
            if ((r_state == ST_FET) && w_done) begin
                r_icode <= icode;
            end
            if (w_in_stage) begin
                r_cycle_count <= r_cycle_count + c_cnt_one;
            end
            if (w_pc_we) begin
                r_instr_count <= r_instr_count + c_cnt_one;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and stage-completion strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_stat_nxt  = r_stat;
        w_cc_we     = 1'b0;
        w_pc_we     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run) begin
                    w_state_nxt = ST_FET;
                end
            end
            ST_FET: begin
                if (w_done) begin
                    if (imem_error) begin
                        w_state_nxt = ST_HALTED;
                        w_stat_nxt  = c_stat_adr;
                    end else if (!instr_valid) begin
                        w_state_nxt = ST_HALTED;
                        w_stat_nxt  = c_stat_ins;
                    end else if (icode == c_icode_halt) begin
                        w_state_nxt = ST_HALTED;
                        w_stat_nxt  = c_stat_hlt;
                    end else begin
                        w_state_nxt = ST_DEC;
                    end
                end
            end
            ST_DEC: begin
                if (w_done) begin
                    w_state_nxt = ST_EXE;
                end
            end
            ST_EXE: begin
                if (w_done) begin
                    w_state_nxt = ST_MEM;
                    w_cc_we     = (r_icode == c_icode_opq);
                end
            end
            ST_MEM: begin
                if (w_done) begin
                    if (dmem_error) begin
                        w_state_nxt = ST_HALTED;
                        w_stat_nxt  = c_stat_adr;
                    end else begin
                        w_state_nxt = ST_WB;
                    end
                end
            end
            ST_WB: begin
                if (w_done) begin
                    w_state_nxt = ST_PCU;
                end
            end
            ST_PCU: begin
                if (w_done) begin
                    w_pc_we     = 1'b1;
                    w_state_nxt = pause ? ST_IDLE : ST_FET;
                end
            end
            ST_HALTED: begin
                w_state_nxt = ST_HALTED;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Expiry only fires without done, so done always wins a tie.
        if (w_expire) begin
            w_state_nxt = ST_HALTED;
            w_stat_nxt  = c_stat_tmo;
        end
    end

    // Pulses are suppressed while reset is asserted so an aborted stage
    // never issues a stray strobe.
    assign stage_go    = (r_first && !reset) ? w_stage_sel : '0;
    assign cc_write_en = w_cc_we && !reset;
    assign pc_write_en = w_pc_we && !reset;
    assign stat        = r_stat;
    assign busy        = w_in_stage;
    assign cycle_count = r_cycle_count;
    assign instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_seq_stage_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_seq_stage_sequencer
//  Description : Self-checking bench for seq_stage_sequencer. A cycle-level
//                behavioural model predicts every output; directed scenarios
//                are followed by randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_stage_sequencer;
    import y86_pkg::*;

    localparam int CNT_W         = 32;
    localparam int STAGE_TIMEOUT = 16;
    localparam int PH_IDLE       = -1;
    localparam int PH_HALT       = 8;

    logic       clk = 1'b0;
    logic       reset, run, pause, instr_valid, imem_error, dmem_error;
    logic [5:0] stage_done;
    logic [3:0] icode;
    logic [5:0] stage_go;
    logic       cc_write_en, pc_write_en, busy;
    logic [2:0] stat;
    logic [CNT_W-1:0] cycle_count, instr_count;

    always #5 clk = ~clk;

    seq_stage_sequencer #(
        .CNT_W         (CNT_W),
        .STAGE_TIMEOUT (STAGE_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .pause       (pause),
        .stage_done  (stage_done),
        .icode       (icode),
        .instr_valid (instr_valid),
        .imem_error  (imem_error),
        .dmem_error  (dmem_error),
        .stage_go    (stage_go),
        .cc_write_en (cc_write_en),
        .pc_write_en (pc_write_en),
        .stat        (stat),
        .busy        (busy),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase (-1 idle, 0..5 stage, 8 halted), cycles spent
    // in the current stage, latched icode, status and counters.
    int          m_ph;
    int          m_age;
    logic [3:0]  m_icode;
    logic [2:0]  m_stat;
    logic [31:0] m_cyc;
    logic [31:0] m_ins;

    // Last sampled outputs, for directed checks.
    logic [5:0] obs_go;
    logic       obs_cc, obs_pc, obs_busy;

    logic [3:0] icode_tab [12];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_enter(input int ph);
        m_ph  = ph;
        m_age = 0;
    endtask

    task automatic model_update();
        if (reset) begin
            m_ph = PH_IDLE; m_age = 0; m_icode = 4'd1;
            m_stat = 3'd1; m_cyc = 0; m_ins = 0;
        end else if (m_ph == PH_IDLE) begin
            if (run) model_enter(0);
        end else if (m_ph >= 0 && m_ph <= 5) begin
            m_cyc = m_cyc + 1;
            if (!stage_done[m_ph]) begin
                m_age = m_age + 1;
                if (m_age == STAGE_TIMEOUT) begin
                    m_stat = 3'd5; m_ph = PH_HALT;
                end
            end else begin
                case (m_ph)
                    0: begin
                        if (imem_error)        begin m_stat = 3'd3; m_ph = PH_HALT; end
                        else if (!instr_valid) begin m_stat = 3'd4; m_ph = PH_HALT; end
                        else if (icode == 4'd0) begin m_stat = 3'd2; m_ph = PH_HALT; end
                        else begin m_icode = icode; model_enter(1); end
                    end
                    3: begin
                        if (dmem_error) begin m_stat = 3'd3; m_ph = PH_HALT; end
                        else model_enter(4);
                    end
                    5: begin
                        m_ins = m_ins + 1;
                        if (pause) begin m_ph = PH_IDLE; m_age = 0; end
                        else model_enter(0);
                    end
                    default: model_enter(m_ph + 1);
                endcase
            end
        end
    endtask

    // One clock cycle: inputs are already driven; sample, compare against
    // the model, then advance the model across the edge.
    task automatic step();
        logic [5:0] e_go;
        logic       e_cc, e_pc, e_busy, d;
        #2;
        obs_go = stage_go; obs_cc = cc_write_en; obs_pc = pc_write_en; obs_busy = busy;
        if (!reset) begin
            e_go = 6'd0; e_cc = 1'b0; e_pc = 1'b0; e_busy = 1'b0;
            if (m_ph >= 0 && m_ph <= 5) begin
                e_busy = 1'b1;
                d = stage_done[m_ph];
                if (m_age == 0) e_go = 6'd1 << m_ph;
                e_cc = (m_ph == 2) && d && (m_icode == 4'd6);
                e_pc = (m_ph == 5) && d;
            end
            check_val("stage_go", 64'(stage_go), 64'(e_go));
            check_val("cc_write_en", 64'(cc_write_en), 64'(e_cc));
            check_val("pc_write_en", 64'(pc_write_en), 64'(e_pc));
            check_val("busy", 64'(busy), 64'(e_busy));
            check_val("stat", 64'(stat), 64'(m_stat));
            check_val("cycle_count", 64'(cycle_count), 64'(m_cyc));
            check_val("instr_count", 64'(instr_count), 64'(m_ins));
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; pause = 1'b0; stage_done = 6'h00;
        icode = 4'd1; instr_valid = 1'b1; imem_error = 1'b0; dmem_error = 1'b0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [5:0] go_or;
        int         stall_left;

        icode_tab = '{c_icode_halt, c_icode_nop, c_icode_cmov, c_icode_irmov,
                      c_icode_rmmov, c_icode_mrmov, c_icode_opq, c_icode_jxx,
                      c_icode_call, c_icode_ret, c_icode_push, c_icode_pop};
        m_ph = PH_IDLE; m_age = 0; m_icode = 4'd1; m_stat = 3'd1; m_cyc = 0; m_ins = 0;

        // Minimum-latency OPq instruction
        do_reset();
        check_val("rst_stat", 64'(stat), 64'd1);
        check_val("rst_busy", 64'(busy), 64'd0);
        run = 1'b1; pause = 1'b1; stage_done = 6'h3f; icode = 4'd6;
        step();
        run = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            check_val("s1_go", 64'(obs_go), 64'(6'd1 << k));
            check_val("s1_cc", 64'(obs_cc), 64'(k == 2));
            check_val("s1_pc", 64'(obs_pc), 64'(k == 5));
        end
        step();
        check_val("s1_instr", 64'(instr_count), 64'd1);
        check_val("s1_cycles", 64'(cycle_count), 64'd6);

        // HALT instruction; run cannot leave HALTED, reset can
        do_reset();
        run = 1'b1; stage_done = 6'h3f; icode = 4'd0;
        for (int k = 0; k < 5; k++) step();
        check_val("hlt_stat", 64'(stat), 64'd2);
        check_val("hlt_busy", 64'(busy), 64'd0);
        check_val("hlt_instr", 64'(instr_count), 64'd0);
        do_reset();
        check_val("hlt_rst_stat", 64'(stat), 64'd1);

        // Data memory fault at MEM
        do_reset();
        run = 1'b1; stage_done = 6'h3f; icode = 4'd5; dmem_error = 1'b1;
        step();
        run = 1'b0;
        go_or = 6'd0;
        for (int k = 0; k < 6; k++) begin
            step();
            go_or = go_or | obs_go;
        end
        check_val("adr_stat", 64'(stat), 64'd3);
        check_val("adr_wb_pcu_go", 64'(go_or & 6'h30), 64'd0);
        check_val("adr_instr", 64'(instr_count), 64'd0);
        dmem_error = 1'b0;

        // EXE timeout, then done on the last allowed cycle
        do_reset();
        run = 1'b1; stage_done = 6'h3f; icode = 4'd6;
        step(); run = 1'b0; step(); step();
        stage_done = 6'h3b;
        for (int k = 0; k < 16; k++) step();
        check_val("tmo_stat", 64'(stat), 64'd5);
        do_reset();
        run = 1'b1; stage_done = 6'h3f; icode = 4'd6;
        step(); run = 1'b0; step(); step();
        for (int k = 1; k <= 16; k++) begin
            stage_done = (k == 16) ? 6'h3f : 6'h3b;
            step();
        end
        stage_done = 6'h3f; pause = 1'b1;
        step();
        check_val("tmo_edge_mem_go", 64'(obs_go), 64'h08);
        check_val("tmo_edge_stat", 64'(stat), 64'd1);
        step(); step(); step();

        // Pause at PCU, resume, then reset mid-DEC
        do_reset();
        run = 1'b1; pause = 1'b1; stage_done = 6'h3f; icode = 4'd1;
        step(); run = 1'b0;
        for (int k = 0; k < 6; k++) step();
        step();
        check_val("pause_busy", 64'(obs_busy), 64'd0);
        run = 1'b1; step(); run = 1'b0;
        step();
        check_val("resume_go", 64'(obs_go), 64'h01);
        stage_done = 6'h00;
        step();
        reset = 1'b1; step(); reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_val("midrst_go", 64'(obs_go), 64'd0);
        end
        check_val("midrst_cycles", 64'(cycle_count), 64'd0);
        check_val("midrst_instr", 64'(instr_count), 64'd0);
        run = 1'b1; stage_done = 6'h3f; step(); run = 1'b0;
        step();
        check_val("midrst_resume_go", 64'(obs_go), 64'h01);

        // Randomized traffic
        stall_left = 0;
        for (int n = 0; n < 4000; n++) begin
            reset = (m_ph == PH_HALT) ? ($urandom_range(0, 3) == 0)
                                      : ($urandom_range(0, 299) == 0);
            run   = ($urandom_range(0, 3) != 0);
            pause = ($urandom_range(0, 3) == 0);
            if (stall_left == 0 && $urandom_range(0, 99) < 2)
                stall_left = $urandom_range(12, 20);
            if (stall_left > 0) begin
                stage_done = 6'h00;
                stall_left--;
            end else begin
                stage_done = 6'($urandom);
            end
            icode       = icode_tab[$urandom_range(0, 11)];
            instr_valid = ($urandom_range(0, 29) != 0);
            imem_error  = ($urandom_range(0, 39) == 0);
            dmem_error  = ($urandom_range(0, 24) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
